// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces a raw push-button, emitting a clean level
// plus single-cycle press, release and long-press pulses.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int LONG_CYCLES     = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // a zero-width hold counter is illegal, so the disabled case keeps one idle bit
    localparam int HW = LONG_CYCLES > 0 ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES > 0 ? LONG_CYCLES - 1 : 0);
    localparam bit LONG_EN = LONG_CYCLES > 0;

    typedef enum logic [1:0] {IDLE, ARM_HI, HELD, ARM_LO} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n;
    logic level_n, press_n, release_n, long_n;
    logic s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], btn_raw};
            state       <= state_n;
            cnt         <= cnt_n;
            hold        <= hold_n;
            btn_level   <= level_n;
            btn_press   <= press_n;
            btn_release <= release_n;
            btn_long    <= long_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hold_n    = hold;
        level_n   = btn_level;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            IDLE: if (s) begin
                state_n = ARM_HI;
                cnt_n   = '0;
            end
            ARM_HI: if (!s) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
                state_n = HELD;
                level_n = 1'b1;
                press_n = 1'b1;
                hold_n  = '0;
            end else
                cnt_n = cnt + CW'(1);
            HELD: if (!s) begin
                state_n = ARM_LO;
                cnt_n   = '0;
            end else begin
                // saturating hold guarantees a single long pulse per press
                if (hold < HOLD_MAX) hold_n = hold + HW'(1);
                long_n = LONG_EN && (hold == HOLD_FIRE);
            end
            ARM_LO: if (s) begin
                state_n = HELD;
                cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
                state_n   = IDLE;
                level_n   = 1'b0;
                release_n = 1'b1;
            end else
                cnt_n = cnt + CW'(1);
            default: state_n = IDLE;
        endcase
    end
endmodule
